mem_access_stage: RTL and testbench

Consumer side of the EX/MEM pipeline register: takes the EX/MEM control and data fields, resolves the branch, runs loads and stores against the data-memory port with a request/ready/response handshake, and loads the MEM/WB pipeline register. While a memory access is in flight it asserts `stall` so that EX/MEM and all earlier stages hold their contents. Word-only accesses; misaligned accesses are trapped without touching memory.

---
 rtl/mem_stage_pkg.sv | 22 ++
 rtl/mem_access_stage_mem_wb.sv | 47 ++++
 rtl/mem_access_stage.sv | 155 +++++++++++++++
 tb/tb_mem_access_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared definitions for the memory-access pipeline stage:
//   - default data/address width and destination-register index width
//   - width of the WB control field and the bubble value loaded into it
//   - state encoding of the memory-access FSM
package mem_stage_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RD_W_DEF = 5;
    localparam int WB_CTL_W = 2;

    // WB control of an instruction that must not write back.
    localparam logic [WB_CTL_W-1:0] WB_BUBBLE = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mem_access_stage_mem_wb.sv
// mem_wb
// MEM/WB pipeline register. When load is high every field takes its new
// value; otherwise a bubble is inserted (WB control cleared) and the data
// fields keep their previous contents.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-low reset
//   load                    1 = load new fields, 0 = insert bubble
//   wb_ctl, alu_result,
//   mem_rdata, rd           fields to load
//   wb_ctl_q, alu_result_q,
//   mem_rdata_q, rd_q       registered MEM/WB fields
module mem_wb
    import mem_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RD_W = RD_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [WB_CTL_W-1:0] wb_ctl,
    input  logic [XLEN-1:0]     alu_result,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic [RD_W-1:0]     rd,
    output logic [WB_CTL_W-1:0] wb_ctl_q,
    output logic [XLEN-1:0]     alu_result_q,
    output logic [XLEN-1:0]     mem_rdata_q,
    output logic [RD_W-1:0]     rd_q
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            wb_ctl_q     <= WB_BUBBLE;
            alu_result_q <= '0;
            mem_rdata_q  <= '0;
            rd_q         <= '0;
        end else if (load) begin
            wb_ctl_q     <= wb_ctl;
            alu_result_q <= alu_result;
            mem_rdata_q  <= mem_rdata;
            rd_q         <= rd;
        end else begin
            wb_ctl_q     <= WB_BUBBLE;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
// Consumer side of the EX/MEM register. Resolves the branch, performs
// word loads/stores over a request/ready/response data-memory port and
// loads the MEM/WB register. While an access is outstanding, stall holds
// EX/MEM and earlier stages. Misaligned accesses are trapped (misalign
// pulse, bubble into MEM/WB) without any bus activity.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-low reset
//   wb_ctl_in, branch, memread,
//   memwrite, zero, add_result,
//   alu_result, rdata2, rd_in    EX/MEM fields
//   dmem_req/we/addr/wdata       memory request (held until dmem_ready)
//   dmem_ready                   request accepted this cycle
//   dmem_rvalid, dmem_rdata      read response
//   stall                        freeze EX/MEM and upstream
//   pcsrc, branch_target         branch decision (combinational)
//   misalign                     one-cycle pulse, registered, for a misaligned access
//   wb_ctl_out, mem_rdata_out,
//   alu_result_out, rd_out       MEM/WB register
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RD_W = RD_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [WB_CTL_W-1:0] wb_ctl_in,
    input  logic                branch,
    input  logic                memread,
    input  logic                memwrite,
    input  logic                zero,
    input  logic [XLEN-1:0]     add_result,
    input  logic [XLEN-1:0]     alu_result,
    input  logic [XLEN-1:0]     rdata2,
    input  logic [RD_W-1:0]     rd_in,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [XLEN-1:0]     dmem_wdata,
    input  logic                dmem_ready,
    input  logic                dmem_rvalid,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic                stall,
    output logic                pcsrc,
    output logic [XLEN-1:0]     branch_target,
    output logic                misalign,
    output logic [WB_CTL_W-1:0] wb_ctl_out,
    output logic [XLEN-1:0]     mem_rdata_out,
    output logic [XLEN-1:0]     alu_result_out,
    output logic [RD_W-1:0]     rd_out
);

    state_t state, state_nxt;

    logic access, aligned, start, bad_align, in_req;

    // Fields captured when an access starts; EX/MEM is frozen meanwhile but
    // keeping private copies makes the bus fields independent of upstream.
    logic [XLEN-1:0]     cap_addr;
    logic [XLEN-1:0]     cap_wdata;
    logic [XLEN-1:0]     cap_rdata;
    logic                cap_we;
    logic [WB_CTL_W-1:0] cap_wb;
    logic [RD_W-1:0]     cap_rd;

    logic                wb_load;
    logic [WB_CTL_W-1:0] wb_ctl_nxt;
    logic [XLEN-1:0]     alu_nxt;
    logic [XLEN-1:0]     rdata_nxt;
    logic [RD_W-1:0]     rd_nxt;

    assign access    = memread | memwrite;
    assign aligned   = (alu_result[1:0] == 2'b00);
    // Accesses are only evaluated in IDLE: in DONE, EX/MEM still holds the
    // instruction that has just completed.
    assign start     = (state == ST_IDLE) & access & aligned;
    assign bad_align = (state == ST_IDLE) & access & ~aligned;
    assign in_req    = (state == ST_REQ);

    assign pcsrc         = branch & zero;
    assign branch_target = add_result;

    assign stall = (state == ST_REQ) | (state == ST_RESP) | start;

    // Bus fields are forced to zero outside REQ.
    assign dmem_req   = in_req;
    assign dmem_we    = in_req & cap_we;
    assign dmem_addr  = in_req ? cap_addr  : '0;
    assign dmem_wdata = in_req ? cap_wdata : '0;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start)       state_nxt = ST_REQ;
            ST_REQ:  if (dmem_ready)  state_nxt = cap_we ? ST_DONE : ST_RESP;
            ST_RESP: if (dmem_rvalid) state_nxt = ST_DONE;
            ST_DONE:                  state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ST_IDLE;
            misalign <= 1'b0;
        end else begin
            state    <= state_nxt;
            misalign <= bad_align;
        end
    end

    // Capture registers carry data only; their contents are meaningless
    // until the next start, so they need no reset. A write takes priority
    // when memread and memwrite are both set.
    always_ff @(posedge clock) begin
        if (start) begin
            cap_addr  <= alu_result;
            cap_wdata <= rdata2;
            cap_we    <= memwrite;
            cap_wb    <= wb_ctl_in;
            cap_rd    <= rd_in;
            cap_rdata <= '0;
        end else if ((state == ST_RESP) && dmem_rvalid) begin
            cap_rdata <= dmem_rdata;
        end
    end

    // MEM/WB loads either a non-memory instruction straight from EX/MEM or
    // a completed access from the capture registers; every other cycle
    // (stall or misaligned trap) inserts a bubble.
    assign wb_load    = (state == ST_DONE) | ((state == ST_IDLE) & ~access);
    assign wb_ctl_nxt = (state == ST_DONE) ? cap_wb    : wb_ctl_in;
    assign alu_nxt    = (state == ST_DONE) ? cap_addr  : alu_result;
    assign rdata_nxt  = (state == ST_DONE) ? cap_rdata : '0;
    assign rd_nxt     = (state == ST_DONE) ? cap_rd    : rd_in;

    mem_wb #(
        .XLEN (XLEN),
        .RD_W (RD_W)
    ) u_mem_wb (
        .clock        (clock),
        .reset        (reset),
        .load         (wb_load),
        .wb_ctl       (wb_ctl_nxt),
        .alu_result   (alu_nxt),
        .mem_rdata    (rdata_nxt),
        .rd           (rd_nxt),
        .wb_ctl_q     (wb_ctl_out),
        .alu_result_q (alu_result_out),
        .mem_rdata_q  (mem_rdata_out),
        .rd_q         (rd_out)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
// Directed bench: a table of single-cycle vectors (ALU ops, branches,
// misaligned accesses) followed by hand-written store, load and
// reset-abort sequences.
module tb_mem_access_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  wb_ctl_in;
    logic        branch, memread, memwrite, zero;
    logic [31:0] add_result, alu_result, rdata2;
    logic [4:0]  rd_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall, pcsrc, misalign;
    logic [31:0] branch_target;
    logic [1:0]  wb_ctl_out;
    logic [31:0] mem_rdata_out, alu_result_out;
    logic [4:0]  rd_out;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mem_access_stage #(.XLEN(32), .RD_W(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .wb_ctl_in      (wb_ctl_in),
        .branch         (branch),
        .memread        (memread),
        .memwrite       (memwrite),
        .zero           (zero),
        .add_result     (add_result),
        .alu_result     (alu_result),
        .rdata2         (rdata2),
        .rd_in          (rd_in),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_ready     (dmem_ready),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .stall          (stall),
        .pcsrc          (pcsrc),
        .branch_target  (branch_target),
        .misalign       (misalign),
        .wb_ctl_out     (wb_ctl_out),
        .mem_rdata_out  (mem_rdata_out),
        .alu_result_out (alu_result_out),
        .rd_out         (rd_out)
    );

    typedef struct {
        logic        br, zr, mr, mw;
        logic [1:0]  wb;
        logic [31:0] alu, add;
        logic [4:0]  rd;
        logic        e_pcsrc, e_mis;
        logic [1:0]  e_wb;
        logic [31:0] e_alu;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic set_nop();
        wb_ctl_in  = 2'b00;
        branch     = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        zero       = 1'b0;
        add_result = 32'h0;
        alu_result = 32'h0;
        rdata2     = 32'h0;
        rd_in      = 5'd0;
    endtask

    int  stall_cnt, req_cnt, resp_cnt;
    logic prev_stall, done;

    initial begin
        // br zr mr mw  wb     alu           add       rd  | pcsrc mis e_wb   e_alu         e_rd
        vecs[0] = '{1'b0,1'b0,1'b0,1'b0,2'b10,32'h0000_1234,32'h0,    5'd7,  1'b0,1'b0,2'b10,32'h0000_1234,5'd7};
        vecs[1] = '{1'b1,1'b1,1'b0,1'b0,2'b01,32'h0,        32'h40,   5'd0,  1'b1,1'b0,2'b01,32'h0,        5'd0};
        vecs[2] = '{1'b1,1'b0,1'b0,1'b0,2'b11,32'hFFFF_FFFC,32'h80,   5'd31, 1'b0,1'b0,2'b11,32'hFFFF_FFFC,5'd31};
        vecs[3] = '{1'b0,1'b0,1'b1,1'b0,2'b11,32'h0000_0102,32'h0,    5'd3,  1'b0,1'b1,2'b00,32'hFFFF_FFFC,5'd31};
        vecs[4] = '{1'b1,1'b1,1'b0,1'b1,2'b10,32'h0000_0101,32'h44,   5'd8,  1'b1,1'b1,2'b00,32'hFFFF_FFFC,5'd31};
        vecs[5] = '{1'b0,1'b1,1'b0,1'b0,2'b01,32'h0000_0008,32'h8C,   5'd2,  1'b0,1'b0,2'b01,32'h0000_0008,5'd2};
        vecs[6] = '{1'b0,1'b0,1'b1,1'b1,2'b11,32'h0000_0003,32'h0,    5'd1,  1'b0,1'b1,2'b00,32'h0000_0008,5'd2};
        vecs[7] = '{1'b0,1'b0,1'b0,1'b0,2'b10,32'hA5A5_A5A4,32'h0,    5'd9,  1'b0,1'b0,2'b10,32'hA5A5_A5A4,5'd9};

        // Reset held two edges with a load pending.
        set_nop();
        reset       = 1'b0;
        memread     = 1'b1;
        alu_result  = 32'h100;
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_wb",     {30'b0, wb_ctl_out}, 32'h0);
        chk("rst_alu",    alu_result_out,      32'h0);
        chk("rst_rdata",  mem_rdata_out,       32'h0);
        chk("rst_rd",     {27'b0, rd_out},     32'h0);
        chk("rst_req",    {31'b0, dmem_req},   32'h0);
        chk("rst_mis",    {31'b0, misalign},   32'h0);
        chk("rst_addr",   dmem_addr,           32'h0);
        @(negedge clock);
        reset   = 1'b1;
        memread = 1'b0;
        #1;
        chk("rst_stall", {31'b0, stall}, 32'h0);

        // Single-cycle vectors.
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            branch     = vecs[i].br;
            zero       = vecs[i].zr;
            memread    = vecs[i].mr;
            memwrite   = vecs[i].mw;
            wb_ctl_in  = vecs[i].wb;
            alu_result = vecs[i].alu;
            add_result = vecs[i].add;
            rd_in      = vecs[i].rd;
            #1;
            chk($sformatf("v%0d_pcsrc", i),  {31'b0, pcsrc},    {31'b0, vecs[i].e_pcsrc});
            chk($sformatf("v%0d_target", i), branch_target,     vecs[i].add);
            chk($sformatf("v%0d_stall", i),  {31'b0, stall},    32'h0);
            chk($sformatf("v%0d_req", i),    {31'b0, dmem_req}, 32'h0);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_mis", i),   {31'b0, misalign},   {31'b0, vecs[i].e_mis});
            chk($sformatf("v%0d_wb", i),    {30'b0, wb_ctl_out}, {30'b0, vecs[i].e_wb});
            chk($sformatf("v%0d_alu", i),   alu_result_out,      vecs[i].e_alu);
            chk($sformatf("v%0d_rd", i),    {27'b0, rd_out},     {27'b0, vecs[i].e_rd});
            chk($sformatf("v%0d_rdata", i), mem_rdata_out,       32'h0);
        end

        // Store with ready low in the first REQ cycle, high in the second.
        @(negedge clock);
        set_nop();
        memwrite   = 1'b1;
        alu_result = 32'h100;
        rdata2     = 32'hDEAD_BEEF;
        wb_ctl_in  = 2'b01;
        rd_in      = 5'd4;
        dmem_ready = 1'b0;
        stall_cnt = 0; req_cnt = 0; prev_stall = 1'b0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (prev_stall) chk("st_bubble", {30'b0, wb_ctl_out}, 32'h0);
            if (stall) stall_cnt++;
            if (dmem_req) begin
                req_cnt++;
                chk("st_addr",  dmem_addr,          32'h100);
                chk("st_wdata", dmem_wdata,         32'hDEAD_BEEF);
                chk("st_we",    {31'b0, dmem_we},   32'h1);
            end
            dmem_ready = dmem_req && (req_cnt == 2);
            if (!stall) begin
                done = 1'b1;
            end else begin
                prev_stall = stall;
                @(negedge clock);
            end
        end
        chk("st_done",   {31'b0, done},     32'h1);
        chk("st_stalls", stall_cnt,         32'd3);
        chk("st_reqs",   req_cnt,           32'd2);
        chk("st_idlereq", {31'b0, dmem_req}, 32'h0);
        set_nop();
        dmem_ready = 1'b0;
        @(posedge clock);
        #1;
        chk("st_wb",    {30'b0, wb_ctl_out}, 32'h1);
        chk("st_alu",   alu_result_out,      32'h100);
        chk("st_rd",    {27'b0, rd_out},     32'd4);
        chk("st_rdata", mem_rdata_out,       32'h0);

        // Load: stray rvalid during REQ, real rvalid in the third RESP cycle,
        // stray rvalid again in DONE.
        @(negedge clock);
        set_nop();
        memread    = 1'b1;
        alu_result = 32'h200;
        wb_ctl_in  = 2'b11;
        rd_in      = 5'd12;
        stall_cnt = 0; req_cnt = 0; resp_cnt = 0; prev_stall = 1'b0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (prev_stall) chk("ld_bubble", {30'b0, wb_ctl_out}, 32'h0);
            if (stall) stall_cnt++;
            if (dmem_req) begin
                req_cnt++;
                chk("ld_addr", dmem_addr,        32'h200);
                chk("ld_we",   {31'b0, dmem_we}, 32'h0);
                dmem_ready  = 1'b1;
                dmem_rvalid = 1'b1;
                dmem_rdata  = 32'hBAD0_BAD0;
            end else if (stall && req_cnt > 0) begin
                resp_cnt++;
                dmem_ready  = 1'b0;
                dmem_rvalid = (resp_cnt == 3);
                dmem_rdata  = (resp_cnt == 3) ? 32'hCAFE_F00D : 32'h1111_1111;
            end else begin
                dmem_ready  = 1'b0;
                dmem_rvalid = 1'b0;
            end
            if (!stall) begin
                done = 1'b1;
            end else begin
                prev_stall = stall;
                @(negedge clock);
            end
        end
        chk("ld_done",   {31'b0, done}, 32'h1);
        chk("ld_stalls", stall_cnt,     32'd5);
        chk("ld_resp",   resp_cnt,      32'd3);
        set_nop();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h2222_2222;
        @(posedge clock);
        #1;
        chk("ld_wb",    {30'b0, wb_ctl_out}, 32'h3);
        chk("ld_alu",   alu_result_out,      32'h200);
        chk("ld_rd",    {27'b0, rd_out},     32'd12);
        chk("ld_rdata", mem_rdata_out,       32'hCAFE_F00D);
        @(negedge clock);
        dmem_rvalid = 1'b0;

        // Reset while waiting in RESP; the late rvalid must be ignored.
        set_nop();
        memread    = 1'b1;
        alu_result = 32'h300;
        wb_ctl_in  = 2'b11;
        rd_in      = 5'd6;
        dmem_ready = 1'b1;
        @(negedge clock);
        #1;
        chk("rs_req", {31'b0, dmem_req}, 32'h1);
        @(negedge clock);
        #1;
        chk("rs_resp_stall", {31'b0, stall},    32'h1);
        chk("rs_resp_req",   {31'b0, dmem_req}, 32'h0);
        reset      = 1'b0;
        dmem_ready = 1'b0;
        @(posedge clock);
        #1;
        chk("rs_wb",    {30'b0, wb_ctl_out}, 32'h0);
        chk("rs_alu",   alu_result_out,      32'h0);
        chk("rs_rdata", mem_rdata_out,       32'h0);
        @(negedge clock);
        reset       = 1'b1;
        set_nop();
        wb_ctl_in   = 2'b01;
        alu_result  = 32'h44;
        rd_in       = 5'd5;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5A5A_5A5A;
        #1;
        chk("rs_idle_stall", {31'b0, stall}, 32'h0);
        @(posedge clock);
        #1;
        chk("rs_late_rdata", mem_rdata_out,       32'h0);
        chk("rs_late_alu",   alu_result_out,      32'h44);
        chk("rs_late_wb",    {30'b0, wb_ctl_out}, 32'h1);
        @(negedge clock);
        dmem_rvalid = 1'b0;
        #1;
        chk("rs_after_req",   {31'b0, dmem_req}, 32'h0);
        chk("rs_after_stall", {31'b0, stall},    32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
